hub75_scanner: RTL and testbench

HUB75_SCANNER -- requirements
Module: hub75_scanner

---
 rtl/hub75_pkg.sv | 11 +
 rtl/hub75_bcm_timer.sv | 25 ++
 rtl/hub75_scanner.sv | 147 ++++++++++++++
 tb/tb_hub75_scanner.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// Shared types and panel geometry for the HUB75 scanner.
package hub75_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, DATA, CLOCK, LATCH, DISPLAY} state_t;

    localparam int COLS      = 64;
    localparam int HALF_ROWS = 16;
    localparam int CH_W      = 8;
    localparam int R_OFS     = 16;
    localparam int G_OFS     = 8;
    localparam int B_OFS     = 0;
endpackage

// File: rtl/hub75_bcm_timer.sv
// Loadable down-counter timing one bit plane's display window.
module hub75_bcm_timer #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         done
);
    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (en && count != '0)
            count <= count - W'(1);
    end

    // Done on the last cycle of the window; a load of N yields N enabled cycles.
    assign done = (count <= W'(1));
endmodule

// File: rtl/hub75_scanner.sv
// HUB75 panel scanner: shifts 64 columns per row per BCM plane, then latches and displays.
module hub75_scanner
    import hub75_pkg::*;
#(
    parameter int ON_TIME = 2,
    parameter int PLANES  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        swap_req,
    output logic        swap_ack,
    output logic        buffer_toggle,
    output logic [9:0]  read_addr,
    output logic        read_en,
    input  logic [31:0] read_data_top,
    input  logic [31:0] read_data_bottom,
    output logic [5:0]  hub75_rgb,
    output logic [3:0]  hub75_row,
    output logic        hub75_clk,
    output logic        hub75_latch,
    output logic        hub75_oe_n
);
    localparam int TW = $clog2((ON_TIME << (PLANES - 1)) + 1);

    state_t       state;
    logic [5:0]   col;
    logic [3:0]   row;
    logic [2:0]   plane;
    logic [2:0]   bit_sel;
    logic         tmr_done;
    logic         last_plane, last_row;
    logic [CH_W-1:0] r_t, g_t, b_t, r_b, g_b, b_b;
    logic [15:0]  unused_hi;

    assign r_t = read_data_top[R_OFS +: CH_W];
    assign g_t = read_data_top[G_OFS +: CH_W];
    assign b_t = read_data_top[B_OFS +: CH_W];
    assign r_b = read_data_bottom[R_OFS +: CH_W];
    assign g_b = read_data_bottom[G_OFS +: CH_W];
    assign b_b = read_data_bottom[B_OFS +: CH_W];
    assign unused_hi = {read_data_top[31:24], read_data_bottom[31:24]};

    // Fewer planes use the MSBs of each channel.
    assign bit_sel    = 3'(8 - PLANES) + plane;
    assign last_plane = (plane == 3'(PLANES - 1));
    assign last_row   = (row == 4'(HALF_ROWS - 1));

    hub75_bcm_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (state == LATCH),
        .en       (state == DISPLAY),
        .load_val (TW'(ON_TIME) << plane),
        .done     (tmr_done)
    );

    // Outputs are set on the edge entering each state so they align with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            col           <= '0;
            row           <= '0;
            plane         <= '0;
            buffer_toggle <= 1'b0;
            swap_ack      <= 1'b0;
            read_en       <= 1'b0;
            read_addr     <= '0;
            hub75_rgb     <= '0;
            hub75_row     <= '0;
            hub75_clk     <= 1'b0;
            hub75_latch   <= 1'b0;
            hub75_oe_n    <= 1'b1;
        end else begin
            swap_ack <= 1'b0;
            case (state)
                IDLE: if (enable) begin
                    col       <= '0;
                    row       <= '0;
                    plane     <= '0;
                    read_en   <= 1'b1;
                    read_addr <= '0;
                    state     <= FETCH;
                end
                FETCH: begin
                    read_en <= 1'b0;
                    state   <= DATA;
                end
                DATA: begin
                    hub75_rgb <= {r_t[bit_sel], g_t[bit_sel], b_t[bit_sel],
                                  r_b[bit_sel], g_b[bit_sel], b_b[bit_sel]};
                    hub75_clk <= 1'b1;
                    state     <= CLOCK;
                end
                CLOCK: begin
                    hub75_clk <= 1'b0;
                    if (col == 6'(COLS - 1)) begin
                        col         <= '0;
                        hub75_latch <= 1'b1;
                        state       <= LATCH;
                    end else begin
                        col       <= col + 6'd1;
                        read_en   <= 1'b1;
                        read_addr <= {row, col + 6'd1};
                        state     <= FETCH;
                    end
                end
                LATCH: begin
                    hub75_latch <= 1'b0;
                    hub75_row   <= row;
                    hub75_oe_n  <= 1'b0;
                    state       <= DISPLAY;
                end
                DISPLAY: if (tmr_done) begin
                    hub75_oe_n <= 1'b1;
                    if (!last_plane) begin
                        plane     <= plane + 3'd1;
                        read_en   <= 1'b1;
                        read_addr <= {row, 6'd0};
                        state     <= FETCH;
                    end else if (!last_row) begin
                        plane     <= '0;
                        row       <= row + 4'd1;
                        read_en   <= 1'b1;
                        read_addr <= {row + 4'd1, 6'd0};
                        state     <= FETCH;
                    end else begin
                        plane <= '0;
                        row   <= '0;
                        if (swap_req) begin
                            buffer_toggle <= ~buffer_toggle;
                            swap_ack      <= 1'b1;
                        end
                        if (enable) begin
                            read_en   <= 1'b1;
                            read_addr <= '0;
                            state     <= FETCH;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hub75_scanner.sv
// Directed bench for hub75_scanner at default parameters, with a registered RAM model.
module tb_hub75_scanner;
    localparam int FRAME = 32864;

    logic        clk = 1'b0;
    logic        reset, enable, swap_req;
    logic        swap_ack, buffer_toggle, read_en;
    logic [9:0]  read_addr;
    logic [31:0] read_data_top = '0, read_data_bottom = '0;
    logic [5:0]  hub75_rgb;
    logic [3:0]  hub75_row;
    logic        hub75_clk, hub75_latch, hub75_oe_n;

    int tests = 0, fails = 0, mon_viol = 0, pattern = 0;

    hub75_scanner dut (
        .clk(clk), .reset(reset), .enable(enable), .swap_req(swap_req),
        .swap_ack(swap_ack), .buffer_toggle(buffer_toggle),
        .read_addr(read_addr), .read_en(read_en),
        .read_data_top(read_data_top), .read_data_bottom(read_data_bottom),
        .hub75_rgb(hub75_rgb), .hub75_row(hub75_row), .hub75_clk(hub75_clk),
        .hub75_latch(hub75_latch), .hub75_oe_n(hub75_oe_n)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pix(input logic [9:0] a, input logic top);
        if (pattern == 0) return 32'h00FF0000;
        if (top && a == 10'(3 * 64 + 5)) return 32'h00000080;
        return 32'h0;
    endfunction

    always @(posedge clk) if (read_en) begin
        read_data_top    <= pix(read_addr, 1'b1);
        read_data_bottom <= pix(read_addr, 1'b0);
    end

    always @(negedge clk)
        if (!reset && hub75_oe_n === 1'b0 && (hub75_latch || hub75_clk)) mon_viol++;

    // Runs one frame from its first FETCH cycle; returns at the next frame's first cycle.
    task automatic run_frame(input int mode, input int swap_at, input int dis_at, input logic exp_tog);
        int shifts = 0, fetches = 0, lat_n = 0, last_lat = 0, exp_at, oe_cnt = 0, hits = 0;
        int rgb_bad = 0, addr_bad = 0, ack_bad = 0, tog_bad = 0, row_bad = 0, lat_bad = 0;
        int r, p, c;
        logic prev_lat = 1'b0;
        logic [5:0] exp_rgb;
        for (int i = 0; i < FRAME; i++) begin
            if (i == swap_at) swap_req = 1'b1;
            if (i == dis_at) enable = 1'b0;
            if (read_en) begin
                c = fetches % 64; p = (fetches / 64) % 8; r = fetches / 512;
                if (read_addr !== 10'(r * 64 + c)) addr_bad++;
                fetches++;
            end
            if (hub75_clk) begin
                c = shifts % 64; p = (shifts / 64) % 8; r = shifts / 512;
                if (mode == 0) exp_rgb = 6'b100100;
                else exp_rgb = (r == 3 && p == 7 && c == 5) ? 6'b001000 : 6'b000000;
                if (hub75_rgb !== exp_rgb) rgb_bad++;
                if (hub75_rgb[3]) hits++;
                shifts++;
            end
            if (!hub75_oe_n) oe_cnt++;
            if (prev_lat && hub75_row !== 4'((lat_n - 1) / 8)) row_bad++;
            if (hub75_latch) begin
                exp_at = (lat_n == 0) ? 192 : last_lat + 193 + (2 << ((lat_n - 1) % 8));
                if (i != exp_at) lat_bad++;
                last_lat = i;
                lat_n++;
            end
            prev_lat = hub75_latch;
            if (i > 0 && swap_ack !== 1'b0) ack_bad++;
            if (i > 0 && buffer_toggle !== exp_tog) tog_bad++;
            @(negedge clk);
        end
        tests++; if (addr_bad != 0) begin fails++; $display("FAIL read_addr_seq: got %0d bad, want 0", addr_bad); end
        tests++; if (fetches != 8192) begin fails++; $display("FAIL fetch_count: got %0d, want 8192", fetches); end
        tests++; if (rgb_bad != 0) begin fails++; $display("FAIL rgb_mode%0d: got %0d bad shifts, want 0", mode, rgb_bad); end
        tests++; if (shifts != 8192) begin fails++; $display("FAIL shift_count: got %0d, want 8192", shifts); end
        tests++; if (oe_cnt != 8160) begin fails++; $display("FAIL oe_cycles: got %0d, want 8160", oe_cnt); end
        tests++; if (lat_n != 128) begin fails++; $display("FAIL latch_count: got %0d, want 128", lat_n); end
        tests++; if (lat_bad != 0) begin fails++; $display("FAIL latch_spacing: got %0d bad, want 0", lat_bad); end
        tests++; if (row_bad != 0) begin fails++; $display("FAIL row_seq: got %0d bad, want 0", row_bad); end
        tests++; if (ack_bad != 0) begin fails++; $display("FAIL ack_midframe: got %0d pulses, want 0", ack_bad); end
        tests++; if (tog_bad != 0) begin fails++; $display("FAIL toggle_midframe: got %0d bad, want 0", tog_bad); end
        if (mode == 1) begin
            tests++; if (hits != 1) begin fails++; $display("FAIL b1_hits: got %0d, want 1", hits); end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; enable = 1'b0; swap_req = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (read_en !== 1'b0 || read_addr !== 10'd0) begin fails++; $display("FAIL rst_read: got en=%b addr=%0d, want 0 0", read_en, read_addr); end
        tests++; if (hub75_rgb !== 6'd0 || hub75_row !== 4'd0) begin fails++; $display("FAIL rst_rgb_row: got %b %0d, want 0 0", hub75_rgb, hub75_row); end
        tests++; if ({hub75_clk, hub75_latch, hub75_oe_n} !== 3'b001) begin fails++; $display("FAIL rst_ctl: got %b, want 001", {hub75_clk, hub75_latch, hub75_oe_n}); end
        tests++; if ({buffer_toggle, swap_ack} !== 2'b00) begin fails++; $display("FAIL rst_swap: got %b, want 00", {buffer_toggle, swap_ack}); end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (read_en !== 1'b0 || hub75_oe_n !== 1'b1) begin fails++; $display("FAIL idle_hold: got en=%b oe_n=%b, want 0 1", read_en, hub75_oe_n); end
    endtask

    task automatic test_start;
        enable = 1'b1;
        @(negedge clk);
        tests++; if (read_en !== 1'b1 || read_addr !== 10'd0) begin fails++; $display("FAIL first_fetch: got en=%b addr=%0d, want 1 0", read_en, read_addr); end
    endtask

    task automatic test_frame_red;
        pattern = 0;
        run_frame(0, 16000, -1, 1'b0);
        tests++; if (swap_ack !== 1'b1 || buffer_toggle !== 1'b1) begin fails++; $display("FAIL swap1: got ack=%b tog=%b, want 1 1", swap_ack, buffer_toggle); end
        tests++; if (read_en !== 1'b1 || read_addr !== 10'd0) begin fails++; $display("FAIL frame_len: got en=%b addr=%0d at 32864, want 1 0", read_en, read_addr); end
    endtask

    task automatic test_frame_pixel_disable;
        pattern = 1;
        run_frame(1, -1, 20000, 1'b1);
        tests++; if (swap_ack !== 1'b1 || buffer_toggle !== 1'b0) begin fails++; $display("FAIL swap2: got ack=%b tog=%b, want 1 0", swap_ack, buffer_toggle); end
        tests++; if (read_en !== 1'b0 || hub75_oe_n !== 1'b1) begin fails++; $display("FAIL stop_idle: got en=%b oe_n=%b, want 0 1", read_en, hub75_oe_n); end
        @(negedge clk);
        tests++; if (swap_ack !== 1'b0) begin fails++; $display("FAIL ack_width: got %b, want 0", swap_ack); end
        repeat (4) @(negedge clk);
        tests++; if (read_en !== 1'b0 || hub75_clk !== 1'b0 || buffer_toggle !== 1'b0) begin fails++; $display("FAIL stay_idle: got en=%b clk=%b tog=%b, want 0 0 0", read_en, hub75_clk, buffer_toggle); end
    endtask

    task automatic test_reset_in_display;
        swap_req = 1'b0; pattern = 0; enable = 1'b1;
        @(negedge clk);
        repeat (193) @(negedge clk);
        tests++; if (hub75_oe_n !== 1'b0 || hub75_rgb !== 6'b100100) begin fails++; $display("FAIL pre_reset: got oe_n=%b rgb=%b, want 0 100100", hub75_oe_n, hub75_rgb); end
        reset = 1'b1; enable = 1'b0;
        @(negedge clk);
        tests++; if (hub75_oe_n !== 1'b1 || hub75_rgb !== 6'd0) begin fails++; $display("FAIL mid_rst_out: got oe_n=%b rgb=%b, want 1 0", hub75_oe_n, hub75_rgb); end
        tests++; if (read_en !== 1'b0 || read_addr !== 10'd0 || hub75_row !== 4'd0) begin fails++; $display("FAIL mid_rst_rd: got en=%b addr=%0d row=%0d, want 0 0 0", read_en, read_addr, hub75_row); end
        tests++; if ({hub75_clk, hub75_latch, swap_ack, buffer_toggle} !== 4'b0000) begin fails++; $display("FAIL mid_rst_ctl: got %b, want 0000", {hub75_clk, hub75_latch, swap_ack, buffer_toggle}); end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (read_en !== 1'b0 || hub75_oe_n !== 1'b1) begin fails++; $display("FAIL post_rst_idle: got en=%b oe_n=%b, want 0 1", read_en, hub75_oe_n); end
    endtask

    task automatic test_monitor;
        tests++; if (mon_viol != 0) begin fails++; $display("FAIL oe_overlap: got %0d cycles, want 0", mon_viol); end
    endtask

    initial begin
        test_reset;
        test_start;
        test_frame_red;
        test_frame_pixel_disable;
        test_reset_in_display;
        test_monitor;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
